block_xfer_unit: RTL
====================

# block_xfer_unit

Multi-cycle engine for the Z80 block-transfer and block-compare group: LDI, LDD, LDIR, LDDR, CPI, CPD, CPIR and CPDR. The control unit hands it HL, DE, BC, A and F, and the engine runs the memory reads and writes itself. It steps the address and count registers, computes flags, and returns updated registers with a done pulse. It sits beside the ALU and drives it: block compares use the ALU's CPB mode as the flag source.

## Interface
Parameters:
- none (16-bit address, 8-bit data fixed by the architecture)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  3  BLK_OP_* code: bit0 = decrement, bit1 = compare, bit2 = repeat
- hl_in, de_in, bc_in  in  16 each  register values, captured on start
- a_in  in  8  accumulator, captured on start (compare ops)
- flags_in  in  6  {S,Z,H,PV,N,C}, captured on start
- abort  in  1  pending-interrupt request; sampled at iteration end
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  16  access address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data; valid in the mem_ack cycle
- mem_ack  in  1  access complete
- hl_out, de_out, bc_out  out  16 each  working registers
- flags_out  out  6  working flags
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE → READ on start.
  - READ → WRITE on mem_ack (LD ops).
  - READ → UPDATE on mem_ack (CP ops).
  - WRITE → UPDATE on mem_ack.
  - UPDATE → READ if a repeat continues.
  - UPDATE → DONE otherwise.
  - DONE → IDLE unconditionally.
- READ: mem_addr = HL, mem_we = 0. The data byte is latched on mem_ack.
- WRITE: mem_addr = DE, mem_we = 1, mem_wdata = latched byte.
- UPDATE, register stepping:
  - HL ± 1; DE ± 1 for LD ops only.
  - BC − 1.
  - All arithmetic is modulo 2^16: 0xFFFF+1 = 0x0000 and 0x0000−1 = 0xFFFF.
  - BC = 0 at start therefore runs 65536 iterations for repeat ops.
- LD flags: H = 0, N = 0, PV = (new BC ≠ 0). S, Z and C are preserved.
- CP flags: S, Z and H come from A − (HL) via the alu in CPB mode; N = 1; PV = (new BC ≠ 0); C is preserved. A is never modified.
- Repeat continues when all of these hold:
  - bit2 is set;
  - new BC ≠ 0;
  - for compares, Z = 0;
  - abort is low in the UPDATE cycle.
- On abort the engine leaves via DONE with the registers and flags of the completed iteration. The control unit re-executes the instruction, so PV = 1 marks an unfinished repeat.
- start while busy is ignored. abort outside UPDATE is ignored.
- Reset values:
  - mem_req, mem_we, busy, done = 0; mem_addr, mem_wdata = 0.
  - hl_out, de_out, bc_out = 0; flags_out = 0; state = IDLE.
- Reset mid-operation: IDLE on the next edge, mem_req low from that edge. A pending write is abandoned.

## Timing
- start in cycle T → busy and mem_req high from T+1 (READ).
- Each access holds for at least 1 cycle. mem_req stays asserted, and mem_addr, mem_we and mem_wdata stay stable, until the cycle in which mem_ack is high.
- mem_ack in the first cycle of a request is legal. mem_ack while mem_req is low is ignored.
- Minimum cycles per iteration, zero-wait memory:
  - LD: 3 (READ, WRITE, UPDATE).
  - CP: 2 (READ, UPDATE).
- hl_out, de_out, bc_out and flags_out update at the end of UPDATE and are final when done is high.
- done is high exactly one cycle, in DONE; busy drops in the following cycle.
- Single LDI with zero-wait memory: start at T, done at T+4, IDLE at T+5.

## Structure
- Shared include blkop.vh holds:
  - BLK_OP_* encodings: LDI = 3'b000, LDD = 3'b001, CPI = 3'b010, CPD = 3'b011; LDIR, LDDR, CPIR, CPDR with bit2 set.
  - State encodings.
- Reuse flags.vh FLAG_IDX_* for flag positions.
- One sub-module: the existing alu, instantiated with mode ALU_MODE_CPB, op_a = A, op_b = latched byte. Only its S, Z and H outputs are consumed.

## Test plan
- LDI, HL=1000h DE=2000h BC=0001h, mem[1000h]=5Ah, F all ones:
  - mem[2000h]=5Ah; HL=1001h, DE=2001h, BC=0000h.
  - PV=0, H=0, N=0; S, Z, C remain 1; done 4 cycles after start.
- LDDR, HL=10FFh DE=20FFh BC=0003h:
  - bytes 10FDh–10FFh copied to 20FDh–20FFh; HL=10FCh, DE=20FCh, BC=0, PV=0; exactly 6 memory accesses.
- CPIR, A=42h, mem[3000h..]=10h,42h,99h, BC=0005h:
  - stops after 2 reads; HL=3002h, BC=0003h, Z=1, PV=1, N=1.
- CPI, A=10h, mem=01h:
  - S=0, Z=0, H=1, N=1; C unchanged; A unchanged.
- Edge cases:
  - LDIR with HL=FFFFh, BC=0002h: second read addresses 0000h.
  - abort during the first UPDATE of an LDIR with BC=0010h: done, BC=000Fh, PV=1.
  - mem_ack delayed 3 cycles: mem_addr held stable throughout.
- Reset asserted during WRITE:
  - mem_req low and busy low after that edge; all outputs at their reset values.
  - a following start runs normally.

Source files
------------

// File: rtl/block_xfer_unit_pkg.sv
// Shared encodings for the Z80 block transfer/compare engine:
// op codes, flag bit positions, FSM states and ALU modes.
package block_xfer_unit_pkg;

   localparam logic [2:0] BLK_OP_LDI  = 3'b000;
   localparam logic [2:0] BLK_OP_LDD  = 3'b001;
   localparam logic [2:0] BLK_OP_CPI  = 3'b010;
   localparam logic [2:0] BLK_OP_CPD  = 3'b011;
   localparam logic [2:0] BLK_OP_LDIR = 3'b100;
   localparam logic [2:0] BLK_OP_LDDR = 3'b101;
   localparam logic [2:0] BLK_OP_CPIR = 3'b110;
   localparam logic [2:0] BLK_OP_CPDR = 3'b111;

   localparam int BLK_OP_DEC = 0;
   localparam int BLK_OP_CMP = 1;
   localparam int BLK_OP_REP = 2;

   localparam int FLAG_IDX_C  = 0;
   localparam int FLAG_IDX_N  = 1;
   localparam int FLAG_IDX_PV = 2;
   localparam int FLAG_IDX_H  = 3;
   localparam int FLAG_IDX_Z  = 4;
   localparam int FLAG_IDX_S  = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_UPDATE,
      ST_DONE
   } blk_state_t;

   typedef enum logic [1:0] {
      ALU_MODE_ADD,
      ALU_MODE_SUB,
      ALU_MODE_CPB
   } alu_mode_t;

   function automatic logic [15:0] step16(input logic [15:0] v,
                                          input logic dec);
      return dec ? v - 16'd1 : v + 16'd1;
   endfunction

endpackage

// File: rtl/block_xfer_unit_alu.sv
// 8-bit ALU slice: S, Z and H for add, subtract and compare.
// Compare (CPB) shares the subtract datapath; the result is discarded.
module block_xfer_unit_alu
   import block_xfer_unit_pkg::*;
(
   input  alu_mode_t  mode,
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   output logic       s,
   output logic       z,
   output logic       h
);

   logic [7:0] res;
   logic [4:0] half;

   always_comb begin
      res  = '0;
      half = '0;
      unique case (mode)
         ALU_MODE_ADD: begin
            res  = op_a + op_b;
            half = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]};
         end
         ALU_MODE_SUB, ALU_MODE_CPB: begin
            res  = op_a - op_b;
            half = {1'b0, op_a[3:0]} - {1'b0, op_b[3:0]};
         end
         default: ;
      endcase
   end

   assign s = res[7];
   assign z = (res == 8'h00);
   assign h = half[4];

endmodule

// File: rtl/block_xfer_unit.sv
// Z80 LDI/LDD/CPI/CPD engine with repeat forms; runs its own
// memory cycles and returns stepped HL/DE/BC and flags.
module block_xfer_unit
   import block_xfer_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [15:0] hl_in,
   input  logic [15:0] de_in,
   input  logic [15:0] bc_in,
   input  logic [7:0]  a_in,
   input  logic [5:0]  flags_in,
   input  logic        abort,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [15:0] hl_out,
   output logic [15:0] de_out,
   output logic [15:0] bc_out,
   output logic [5:0]  flags_out,
   output logic        busy,
   output logic        done
);

   blk_state_t  state;
   logic [2:0]  op_r;
   logic [7:0]  a_r;
   logic [7:0]  data_r;
   logic        dec, cmp, rep;
   logic [15:0] hl_n, de_n, bc_n;
   logic [5:0]  flags_n;
   logic        bc_nz, cont;
   logic        alu_s, alu_z, alu_h;

   assign dec = op_r[BLK_OP_DEC];
   assign cmp = op_r[BLK_OP_CMP];
   assign rep = op_r[BLK_OP_REP];

   block_xfer_unit_alu u_alu (
      .mode (ALU_MODE_CPB),
      .op_a (a_r),
      .op_b (data_r),
      .s    (alu_s),
      .z    (alu_z),
      .h    (alu_h)
   );

   always_comb begin
      hl_n    = step16(hl_out, dec);
      de_n    = cmp ? de_out : step16(de_out, dec);
      bc_n    = bc_out - 16'd1;
      bc_nz   = (bc_n != 16'h0000);
      flags_n = flags_out;
      flags_n[FLAG_IDX_PV] = bc_nz;
      if (cmp) begin
         flags_n[FLAG_IDX_S] = alu_s;
         flags_n[FLAG_IDX_Z] = alu_z;
         flags_n[FLAG_IDX_H] = alu_h;
         flags_n[FLAG_IDX_N] = 1'b1;
      end else begin
         flags_n[FLAG_IDX_H] = 1'b0;
         flags_n[FLAG_IDX_N] = 1'b0;
      end
      cont = rep && bc_nz && !(cmp && alu_z) && !abort;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_r      <= '0;
         a_r       <= '0;
         data_r    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         hl_out    <= '0;
         de_out    <= '0;
         bc_out    <= '0;
         flags_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  op_r      <= op;
                  a_r       <= a_in;
                  hl_out    <= hl_in;
                  de_out    <= de_in;
                  bc_out    <= bc_in;
                  flags_out <= flags_in;
                  busy      <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= hl_in;
                  state     <= ST_READ;
               end
            end
            ST_READ: begin
               if (mem_ack) begin
                  data_r <= mem_rdata;
                  if (cmp) begin
                     mem_req <= 1'b0;
                     state   <= ST_UPDATE;
                  end else begin
                     mem_we    <= 1'b1;
                     mem_addr  <= de_out;
                     mem_wdata <= mem_rdata;
                     state     <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               hl_out    <= hl_n;
               de_out    <= de_n;
               bc_out    <= bc_n;
               flags_out <= flags_n;
               if (cont) begin
                  mem_req  <= 1'b1;
                  mem_addr <= hl_n;
                  state    <= ST_READ;
               end else begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
